// File: rtl/stream_demux_1_n_if.sv
// Stream demux bundle: one producer-side valid/ready stream and N consumer lanes.
//   mode      : 0 = addressed (in_sel picks the lane), 1 = round-robin
//   in_data   : producer payload
//   in_sel    : destination lane in addressed mode
//   in_valid  : producer has a word
//   in_ready  : demux accepts the word this cycle
//   out_data  : lane k payload at [k*DATA_W +: DATA_W]
//   out_valid : lane k holds a word
//   out_ready : consumer k takes its word
//   rr_ptr    : next round-robin lane
//   err_cnt   : saturating count of dropped out-of-range words
// master = producer/consumer side, slave = the demux itself.
interface stream_demux_1_n_if #(
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_OUT),
  parameter int unsigned ERR_W  = 8
);
  logic                      mode;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [SEL_W-1:0]          rr_ptr;
  logic [ERR_W-1:0]          err_cnt;

  modport master (
    output mode, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, err_cnt
  );

  modport slave (
    input  mode, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, err_cnt
  );
endinterface

// File: rtl/stream_demux_1_n.sv
// Registered 1:N stream demultiplexer with one holding register per output lane.
// A stalled lane only blocks words aimed at it; other lanes keep flowing.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : stream_demux_1_n_if.slave (input stream, N output lanes, rr_ptr, err_cnt)
// Target is in_sel (addressed) or rr_ptr (round-robin). Out-of-range targets are
// always accepted and dropped, bumping the saturating err_cnt. Lane latency is
// one cycle; there is no combinational path from in_data to out_data.
module stream_demux_1_n #(
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_OUT),
  parameter int unsigned ERR_W  = 8
) (
  input logic               clk,
  input logic               rst,
  stream_demux_1_n_if.slave bus
);

  localparam int unsigned NSel = 2 ** SEL_W;

  logic [N_OUT*DATA_W-1:0] data_q;
  logic [N_OUT-1:0]        valid_q;
  logic [SEL_W-1:0]        rr_ptr_q;
  logic [ERR_W-1:0]        err_q;

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             ready;
  logic             acc;
  logic [N_OUT-1:0] load;
  // Lane state padded to the full select range so tgt can index it safely.
  logic [NSel-1:0]  valid_ext;
  logic [NSel-1:0]  oready_ext;

  always_comb begin
    valid_ext                = '0;
    oready_ext               = '0;
    valid_ext[N_OUT-1:0]     = valid_q;
    oready_ext[N_OUT-1:0]    = bus.out_ready;
  end

  assign tgt    = bus.mode ? rr_ptr_q : bus.in_sel;
  assign tgt_ok = (32'(tgt) < N_OUT);
  // Pass-through drain: a full lane being emptied this cycle can take a new word.
  assign ready  = !tgt_ok || !valid_ext[tgt] || oready_ext[tgt];
  assign acc    = bus.in_valid && ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = acc && (tgt == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        // Load takes priority over a simultaneous drain.
        if (load[k]) begin
          data_q[k*DATA_W +: DATA_W] <= bus.in_data;
          valid_q[k]                 <= 1'b1;
        end else if (valid_q[k] && bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (acc && bus.mode) begin
      rr_ptr_q <= (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (acc && !tgt_ok && (err_q != {ERR_W{1'b1}})) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.rr_ptr    = rr_ptr_q;
  assign bus.err_cnt   = err_q;

endmodule
